// File: rtl/spi_adc128s_if.sv
// rtl/spi_adc128s_if.sv - master-driven SPI bus lines for the ADC128S serial port
interface spi_adc128s_if;
   logic SS_n;
   logic SCLK;
   logic MOSI;

   modport master (output SS_n, SCLK, MOSI);
   modport slave  (input  SS_n, SCLK, MOSI);
endinterface

// File: rtl/spi_adc128s.sv
// rtl/spi_adc128s.sv - oversampled SPI slave: 16-bit command in on MOSI, 16-bit A2D word out on MISO
module spi_adc128s (
   input  logic                clk,
   input  logic                rst_n,
   spi_adc128s_if.slave        spi,
   output logic                MISO,
   input  logic [15:0]         A2D_data,
   output logic [15:0]         cmd,
   output logic                rdy
);

   typedef enum logic {IDLE, XFER} state_t;

   logic [2:0]  sclk_q;
   logic [2:0]  ss_q;
   logic [1:0]  mosi_q;
   state_t      state_q;
   logic [15:0] shreg_q;
   logic [4:0]  cnt_q;
   logic [15:0] cmd_q;
   logic        rdy_q;

   logic ss_fall;
   logic ss_rise;
   logic sclk_rise;

   // Stage [1] is the synchronized level, stage [2] is the previous level for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q <= 3'b111;
         ss_q   <= 3'b111;
         mosi_q <= 2'b00;
      end else begin
         sclk_q <= {sclk_q[1:0], spi.SCLK};
         ss_q   <= {ss_q[1:0], spi.SS_n};
         mosi_q <= {mosi_q[0], spi.MOSI};
      end
   end

   assign ss_fall   =  ss_q[2] & ~ss_q[1];
   assign ss_rise   = ~ss_q[2] &  ss_q[1];
   assign sclk_rise = ~sclk_q[2] & sclk_q[1];

   // A load on SS_n fall wins over a coincident SCLK rise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shreg_q <= 16'h0000;
         cnt_q   <= 5'd0;
         cmd_q   <= 16'h0000;
         rdy_q   <= 1'b0;
      end else if (ss_fall) begin
         state_q <= XFER;
         shreg_q <= A2D_data;
         cnt_q   <= 5'd0;
         rdy_q   <= 1'b0;
      end else if (ss_rise) begin
         state_q <= IDLE;
         if (cnt_q == 5'd16) begin
            cmd_q <= shreg_q;
            rdy_q <= 1'b1;
         end
      end else if (sclk_rise && state_q == XFER) begin
         shreg_q <= {shreg_q[14:0], mosi_q[1]};
         if (cnt_q != 5'd16)
            cnt_q <= cnt_q + 5'd1;
      end
   end

   assign MISO = spi.SS_n ? 1'bz : shreg_q[15];
   assign cmd  = cmd_q;
   assign rdy  = rdy_q;

endmodule

// File: tb/tb_spi_adc128s.sv
// tb/tb_spi_adc128s.sv - directed and random SPI transactions checked against a word-level model
module tb_spi_adc128s;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] A2D_data;
   logic [15:0] cmd;
   logic        rdy;
   wire         miso;

   spi_adc128s_if spi();

   spi_adc128s dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .spi      (spi),
      .MISO     (miso),
      .A2D_data (A2D_data),
      .cmd      (cmd),
      .rdy      (rdy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_cmd;
   logic        exp_rdy;

   task automatic ticks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Master sees the A2D word first, then the bits it sent itself once the word has drained
   function automatic logic [31:0] model_rx(input logic [15:0] a2d, input logic [31:0] tx, input int n);
      if (n >= 16)
         return ({16'h0000, a2d} << (n - 16)) | (tx >> 16);
      else
         return {16'h0000, a2d} >> (16 - n);
   endfunction

   task automatic start(input logic [15:0] a2d);
      A2D_data = a2d;
      spi.SS_n = 1'b0;
      ticks(6);
      check("rdy_low_in_xfer", {31'b0, rdy}, 32'd0);
      check("miso_first_bit", {31'b0, miso}, {31'b0, a2d[15]});
   endtask

   task automatic clock_bits(input logic [31:0] tx, input int n, output logic [31:0] rx);
      rx = 32'd0;
      for (int i = 0; i < n; i++) begin
         spi.MOSI = tx[n-1-i];
         spi.SCLK = 1'b0;
         ticks(10);
         rx = {rx[30:0], miso};
         spi.SCLK = 1'b1;
         ticks(10);
      end
   endtask

   task automatic xfer(input logic [15:0] a2d, input logic [31:0] tx_in, input int n, input string tag);
      logic [31:0] tx;
      logic [31:0] rx;
      tx = (n >= 32) ? tx_in : (tx_in & ((32'd1 << n) - 32'd1));
      start(a2d);
      clock_bits(tx, n, rx);
      spi.SS_n = 1'b1;
      ticks(8);
      if (n >= 16) begin
         exp_cmd = tx[15:0];
         exp_rdy = 1'b1;
      end else begin
         exp_rdy = 1'b0;
      end
      check({tag, "_miso"}, rx, model_rx(a2d, tx, n));
      check({tag, "_cmd"}, {16'h0000, cmd}, {16'h0000, exp_cmd});
      check({tag, "_rdy"}, {31'b0, rdy}, {31'b0, exp_rdy});
   endtask

   int          ntab [8] = '{16, 16, 17, 12, 18, 16, 15, 20};
   logic [31:0] rx_tmp;

   initial begin
      spi.SS_n = 1'b1;
      spi.SCLK = 1'b1;
      spi.MOSI = 1'b0;
      A2D_data = 16'h0000;
      exp_cmd  = 16'h0000;
      exp_rdy  = 1'b0;
      rst_n    = 1'b0;
      ticks(3);
      check("reset_cmd", {16'h0000, cmd}, 32'd0);
      check("reset_rdy", {31'b0, rdy}, 32'd0);
      rst_n = 1'b1;
      ticks(3);

      // SS_n low with no SCLK, then released: nothing received
      start(16'hA5A5);
      spi.SS_n = 1'b1;
      ticks(8);
      check("empty_cmd", {16'h0000, cmd}, 32'd0);
      check("empty_rdy", {31'b0, rdy}, 32'd0);

      xfer(16'h0C00, 32'h2800, 16, "full");
      xfer(16'h0123, 32'h2000, 16, "b2b_first");
      xfer(16'h0BF0, 32'h2000, 16, "b2b_second");
      xfer(16'h7E81, 32'h0000_02AA, 10, "abort");
      xfer(16'hC3C3, 32'h0003_FFFF, 18, "over16");

      // Async reset in the middle of a transfer
      start(16'h9999);
      clock_bits(32'h0000_00A5, 7, rx_tmp);
      rst_n = 1'b0;
      #1;
      exp_cmd = 16'h0000;
      exp_rdy = 1'b0;
      check("midreset_cmd", {16'h0000, cmd}, 32'd0);
      check("midreset_rdy", {31'b0, rdy}, 32'd0);
      spi.SS_n = 1'b1;
      spi.SCLK = 1'b1;
      ticks(3);
      rst_n = 1'b1;
      ticks(4);
      xfer(16'h4321, 32'h1234, 16, "after_reset");

      for (int k = 0; k < 8; k++)
         xfer(16'($urandom), $urandom, ntab[k], "random");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
